// File: rtl/loader_pkg.sv
// Shared types and helpers for the vector loader.
//   state_e   : load controller states
//   cnt_width : bit width needed to count 0..n-1 (never less than 1)
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Assembles W-bit elements from a byte stream.
//   clk_i, reset_i : clock, synchronous active-high reset
//   strobe_i       : current byte on data_i is valid
//   big_endian_i   : 1 -> byte 0 lands in the MSB lane, 0 -> byte 0 in the LSB lane
//   byte_idx_i     : position of the current byte within the element
//   data_i         : received byte
//   word_o         : assembly register with the current byte already merged in,
//                    so the caller can store a complete element on the same edge
//                    as its last byte
module byte_assembler
  import loader_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        strobe_i,
  input  logic                        big_endian_i,
  input  logic [cnt_width(W/8)-1:0]   byte_idx_i,
  input  logic [7:0]                  data_i,
  output logic [W-1:0]                word_o
);

  localparam int unsigned NB = W / 8;
  localparam int unsigned BW = cnt_width(NB);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (strobe_i) begin
      for (int unsigned k = 0; k < NB; k++) begin
        // Lane k receives byte idx (LE) or byte NB-1-idx (BE).
        if ((!big_endian_i && (BW'(k) == byte_idx_i)) ||
            ( big_endian_i && (BW'(NB - 1 - k) == byte_idx_i))) begin
          acc_d[8*k +: 8] = data_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign word_o = acc_d;

endmodule

// File: rtl/vector_loader.sv
// Loads N-element vectors of W-bit values, received one byte at a time,
// into one of NBUF buffers.
//   clk, reset  : clock, synchronous active-high reset
//   start       : begin a load into buffer sel with byte order big_endian
//   rx_ready    : rx_data holds a valid byte this cycle
//   busy        : a load is in progress (through the done/err_timeout cycle)
//   done        : one-cycle pulse, vector complete
//   err_timeout : one-cycle pulse, load abandoned after TIMEOUT idle cycles
//   valid       : per-buffer complete-vector flag
//   vec_out     : all buffers; element e of buffer b is at [(b*N+e)*W +: W]
module vector_loader
  import loader_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = 16,
  parameter int unsigned NBUF    = 2,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [cnt_width(NBUF)-1:0]    sel,
  input  logic                          big_endian,
  input  logic                          rx_ready,
  input  logic [7:0]                    rx_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err_timeout,
  output logic [NBUF-1:0]               valid,
  output logic [NBUF*N*W-1:0]           vec_out
);

  localparam int unsigned NB = W / 8;
  localparam int unsigned SW = cnt_width(NBUF);
  localparam int unsigned BW = cnt_width(NB);
  localparam int unsigned EW = cnt_width(N);
  localparam int unsigned TW = cnt_width(TIMEOUT);

  localparam logic [SW:0]   NBUF_L    = (SW+1)'(NBUF);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);
  localparam logic [EW-1:0] ELEM_LAST = EW'(N - 1);
  // The error fires on the edge where the counter would reach TIMEOUT-1.
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 2);

  state_e               state_q;
  logic [SW-1:0]        sel_q;
  logic                 be_q;
  logic [BW-1:0]        byte_q;
  logic [EW-1:0]        elem_q;
  logic [TW-1:0]        to_q;
  logic [NBUF*N*W-1:0]  vec_q;
  logic [NBUF-1:0]      valid_q;
  logic                 done_q;
  logic                 err_q;
  logic                 busy_q;

  logic                 sel_ok;
  logic                 rx_take;
  logic [W-1:0]         asm_word;
  int unsigned          wr_base;

  assign sel_ok  = ({1'b0, sel} < NBUF_L);
  assign rx_take = (state_q == RECV) && rx_ready;

  always_comb begin
    wr_base = (32'(sel_q) * N + 32'(elem_q)) * W;
  end

  byte_assembler #(
    .W (W)
  ) u_asm (
    .clk_i        (clk),
    .reset_i      (reset),
    .strobe_i     (rx_take),
    .big_endian_i (be_q),
    .byte_idx_i   (byte_q),
    .data_i       (rx_data),
    .word_o       (asm_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      be_q    <= 1'b0;
      byte_q  <= '0;
      elem_q  <= '0;
      to_q    <= '0;
      vec_q   <= '0;
      valid_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && sel_ok) begin
            sel_q        <= sel;
            be_q         <= big_endian;
            byte_q       <= '0;
            elem_q       <= '0;
            to_q         <= '0;
            valid_q[sel] <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= RECV;
          end
        end
        RECV: begin
          // A byte arriving in the would-be timeout cycle wins over the error.
          if (rx_ready) begin
            to_q <= '0;
            if (byte_q == BYTE_LAST) begin
              byte_q               <= '0;
              vec_q[wr_base +: W]  <= asm_word;
              if (elem_q == ELEM_LAST) begin
                elem_q         <= '0;
                valid_q[sel_q] <= 1'b1;
                done_q         <= 1'b1;
                state_q        <= DONE;
              end else begin
                elem_q <= elem_q + 1'b1;
              end
            end else begin
              byte_q <= byte_q + 1'b1;
            end
          end else if (to_q == TO_LAST) begin
            to_q    <= '0;
            err_q   <= 1'b1;
            state_q <= ERROR;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        ERROR: begin
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err_timeout = err_q;
  assign valid       = valid_q;
  assign vec_out     = vec_q;

endmodule

// File: tb/tb_vector_loader.sv
module tb_vector_loader;

  localparam int N = 4;
  localparam int W = 16;
  localparam int NBUF = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [0:0]           sel;
  logic                 big_endian;
  logic                 rx_ready;
  logic [7:0]           rx_data;
  logic                 busy;
  logic                 done;
  logic                 err_timeout;
  logic [NBUF-1:0]      valid;
  logic [NBUF*N*W-1:0]  vec_out;

  int n_chk = 0;
  int n_err = 0;

  vector_loader #(
    .N       (N),
    .W       (W),
    .NBUF    (NBUF),
    .TIMEOUT (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .sel         (sel),
    .big_endian  (big_endian),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .valid       (valid),
    .vec_out     (vec_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] el(input int b, input int e);
    return vec_out[(b*N+e)*W +: W];
  endfunction

  // Inputs change at the falling edge; outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input logic s, input logic be);
    start = 1'b1; sel = s; big_endian = be;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_ready = 1'b1; rx_data = b;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sel = '0; big_endian = 1'b0;
    rx_ready = 1'b0; rx_data = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_vec_lo", vec_out[63:0], 64'd0);
    chk("rst_vec_hi", vec_out[127:64], 64'd0);

    // Little-endian load into buffer 0
    do_start(1'b0, 1'b0);
    chk("le_busy", 64'(busy), 64'd1);
    for (int i = 1; i <= 7; i++) send_byte(8'(i));
    chk("le_done_early", 64'(done), 64'd0);
    send_byte(8'h08);
    chk("le_done", 64'(done), 64'd1);
    chk("le_valid", 64'(valid), 64'b01);
    chk("le_busy_done", 64'(busy), 64'd1);
    tick();
    chk("le_done_fall", 64'(done), 64'd0);
    chk("le_busy_fall", 64'(busy), 64'd0);
    chk("le_e0", 64'(el(0,0)), 64'h0201);
    chk("le_e1", 64'(el(0,1)), 64'h0403);
    chk("le_e2", 64'(el(0,2)), 64'h0605);
    chk("le_e3", 64'(el(0,3)), 64'h0807);

    // Big-endian load into buffer 1
    do_start(1'b1, 1'b1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    chk("be_done", 64'(done), 64'd1);
    chk("be_valid", 64'(valid), 64'b11);
    chk("be_e0", 64'(el(1,0)), 64'h0102);
    chk("be_e1", 64'(el(1,1)), 64'h0304);
    chk("be_e2", 64'(el(1,2)), 64'h0506);
    chk("be_e3", 64'(el(1,3)), 64'h0708);
    chk("be_buf0_kept", vec_out[63:0], 64'h0807_0605_0403_0201);
    tick();

    // Timeout: 3 bytes then silence, error 20 cycles after the 3rd strobe
    do_start(1'b0, 1'b0);
    chk("to_valid_clr", 64'(valid), 64'b10);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    for (int i = 0; i < 18; i++) tick();
    chk("to_err_early", 64'(err_timeout), 64'd0);
    tick();
    chk("to_err", 64'(err_timeout), 64'd1);
    chk("to_busy_err", 64'(busy), 64'd1);
    chk("to_valid", 64'(valid), 64'b10);
    chk("to_e0", 64'(el(0,0)), 64'hBBAA);
    chk("to_e1_kept", 64'(el(0,1)), 64'h0403);
    chk("to_buf1_kept", vec_out[127:64], 64'h0708_0506_0304_0102);
    tick();
    chk("to_err_fall", 64'(err_timeout), 64'd0);
    chk("to_busy_fall", 64'(busy), 64'd0);

    // Byte in the exact timeout cycle is accepted
    do_start(1'b1, 1'b0);
    send_byte(8'h11);
    for (int i = 0; i < 18; i++) tick();
    send_byte(8'h22);
    chk("edge_no_err", 64'(err_timeout), 64'd0);
    chk("edge_busy", 64'(busy), 64'd1);
    chk("edge_e0", 64'(el(1,0)), 64'h2211);
    for (int i = 3; i <= 8; i++) send_byte(8'(i * 16 + i));
    chk("edge_done", 64'(done), 64'd1);
    chk("edge_valid", 64'(valid), 64'b10);
    chk("edge_e1", 64'(el(1,1)), 64'h4433);
    chk("edge_e3", 64'(el(1,3)), 64'h8877);
    tick();

    // start during RECV and rx_ready in IDLE are ignored
    do_start(1'b0, 1'b0);
    send_byte(8'h10); send_byte(8'h20);
    do_start(1'b1, 1'b1);
    chk("ign_valid", 64'(valid), 64'b10);
    for (int i = 3; i <= 8; i++) send_byte(8'(i * 16));
    chk("ign_done", 64'(done), 64'd1);
    chk("ign_valid_set", 64'(valid), 64'b11);
    chk("ign_buf0", vec_out[63:0], 64'h8070_6050_4030_2010);
    tick();
    send_byte(8'hFF); send_byte(8'hEE);
    chk("idle_rx_busy", 64'(busy), 64'd0);
    chk("idle_rx_buf0", vec_out[63:0], 64'h8070_6050_4030_2010);
    chk("idle_rx_buf1", vec_out[127:64], 64'h8877_6655_4433_2211);

    // Reset after 5 bytes, then a fresh load
    do_start(1'b1, 1'b1);
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_valid", 64'(valid), 64'd0);
    chk("mr_vec", 64'(|vec_out), 64'd0);
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done || err_timeout) chk("mr_pulse", {62'd0, done, err_timeout}, 64'd0);
    end
    chk("mr_quiet", {62'd0, done, err_timeout}, 64'd0);
    do_start(1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    chk("mr_done", 64'(done), 64'd1);
    chk("mr_valid2", 64'(valid), 64'b01);
    chk("mr_buf0", vec_out[63:0], 64'h0807_0605_0403_0201);
    chk("mr_buf1", vec_out[127:64], 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vector_loader.md
VECTOR_LOADER -- requirements
Module: vector_loader

Interface
REQ-001 Parameter N, default 4, SHALL set the number of elements per vector.
REQ-002 Parameter W, default 16, SHALL set the element width in bits and SHALL be a multiple of 8 (1..4 bytes).
REQ-003 Parameter NBUF, default 2, SHALL set the number of independently addressable vector buffers.
REQ-004 Parameter TIMEOUT, default 100000, SHALL set the maximum idle clk cycles allowed between received bytes.
REQ-005 clk  input  1  clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to begin loading a vector.
REQ-008 sel  input  max(1,$clog2(NBUF))  target buffer index, sampled with start.
REQ-009 big_endian  input  1  byte order, sampled with start (1: first byte -> MSB).
REQ-010 rx_ready  input  1  one-cycle strobe marking rx_data valid.
REQ-011 rx_data  input  8  received byte.
REQ-012 busy  output  1  high from the cycle after an accepted start until the cycle after done or err_timeout.
REQ-013 done  output  1  one-cycle pulse: vector completely written.
REQ-014 err_timeout  output  1  one-cycle pulse: load aborted by timeout.
REQ-015 valid  output  NBUF  per-buffer flag: buffer holds a complete vector.
REQ-016 vec_out  output  NBUF x N x W  buffer contents, registered.

Function
REQ-017 States SHALL be IDLE, RECV, DONE, ERROR.
REQ-018 IDLE: start=1 SHALL latch sel and big_endian, clear byte and element counters, clear valid[sel], and go to RECV.
REQ-019 sel >= NBUF SHALL cause start to be ignored (stay IDLE, no flag change).
REQ-020 start while not IDLE SHALL be ignored; rx_ready in IDLE, DONE or ERROR SHALL be ignored.
REQ-021 RECV: each rx_ready SHALL shift rx_data into an element assembly register and increment the byte counter (0..W/8-1).
REQ-022 Little-endian: byte k of an element SHALL land in bits [8k+7:8k]; big-endian: byte k SHALL land in bits [W-1-8k:W-8-8k].
REQ-023 On the last byte of an element, the assembled value SHALL be written to vec_out[sel][elem] on the same edge, the byte counter SHALL wrap to 0, and elem SHALL increment.
REQ-024 On the last byte of element N-1, the FSM SHALL go to DONE; done SHALL be high exactly the next cycle, and valid[sel] SHALL set on that edge.
REQ-025 DONE SHALL last one cycle, then return to IDLE; back-to-back start is accepted in the IDLE cycle after DONE.
REQ-026 A timeout counter SHALL clear on entry to RECV and on each rx_ready, and increment otherwise in RECV.
REQ-027 Counter reaching TIMEOUT-1 without rx_ready SHALL move to ERROR; err_timeout high one cycle, then IDLE.
REQ-028 After timeout, elements already written SHALL remain in vec_out and valid[sel] SHALL stay 0.
REQ-029 rx_ready in the same cycle the timeout would fire SHALL take priority (byte accepted, no error).
REQ-030 Non-selected buffers and their valid bits SHALL never change during a load.

Reset
REQ-031 reset SHALL force IDLE, clear all counters, vec_out to 0, valid to 0, done, err_timeout and busy to 0.
REQ-032 reset mid-load SHALL abandon the load with no done or err_timeout pulse.

Structure
REQ-033 The state enum and a byte-count width helper SHALL live in package loader_pkg.
REQ-034 Byte assembly (shift + endian placement) SHALL be sub-module byte_assembler; the FSM, counters and buffers stay in vector_loader.

Verification
REQ-035 N=4,W=16,LE, sel=0, bytes 01 02 03 04 05 06 07 08 -> vec_out[0]={0x0201,0x0403,0x0605,0x0807}, done 1 cycle after 8th strobe, valid=01.
REQ-036 Same bytes, big_endian=1, sel=1 -> vec_out[1]={0x0102,0x0304,0x0506,0x0708}, valid=11, buffer 0 unchanged.
REQ-037 TIMEOUT=20, 3 bytes then silence -> err_timeout 20 cycles after 3rd strobe, element 0 written, valid[sel]=0, busy falls.
REQ-038 Byte strobe in the exact timeout cycle -> accepted, no err_timeout.
REQ-039 start during RECV and rx_ready in IDLE -> ignored, outputs unchanged.
REQ-040 reset after 5 bytes -> all outputs 0 next cycle, no pulses; fresh load then completes normally.
